bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It accepts one unsigned binary word over a valid/ready handshake, converts it over BIN_W clock cycles, and presents packed BCD digits on a valid/ready output. It sits directly upstream of the BCD-to-excess-3 converter, feeding it one BCD nibble per digit.

---
 rtl/bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using iterative shift-and-add-3
// (double dabble). One unsigned word is accepted over a valid/ready handshake.
// The word is converted over BIN_W clock cycles. The packed BCD result is then
// held on a valid/ready output until the consumer takes it.
//
// Parameters
//   BIN_W   width of the binary operand; also the number of shift iterations
//   DIGITS  number of BCD digits produced; 10**DIGITS must exceed 2**BIN_W - 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   bin is presented for conversion
//   in_ready   block can accept a new word (IDLE)
//   bin        unsigned operand, sampled only on the accept edge
//   out_valid  bcd holds a completed result (DONE)
//   out_ready  consumer takes the result
//   bcd        packed BCD, digit k in bits [4k+3:4k], digit 0 = units
//   busy       high while the conversion is in progress (SHIFT)
//   xs3        (only with BIN_TO_BCD_XS3_EN) excess-3 copy of bcd, valid
//              while out_valid is high
//
// Optional feature macro: BIN_TO_BCD_XS3_EN
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN_TO_BCD_XS3_EN
    output logic [4*DIGITS-1:0]   xs3,
`endif
    output logic                  busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Add 3 to every digit that is 5 or more, so that the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end else begin
                res[4*k +: 4] = acc[4*k +: 4];
            end
        end
        return res;
    endfunction

    // Excess-3 encoding of every BCD digit.
    function automatic logic [BCD_W-1:0] plus3_digits(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int k = 0; k < DIGITS; k++) begin
            res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        return res;
    endfunction

    state_e             state_q,     state_d;
    logic [BIN_W-1:0]   bin_q,       bin_d;
    logic [BCD_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
`ifdef BIN_TO_BCD_XS3_EN
    logic [BCD_W-1:0]   xs3_q,       xs3_d;
`endif
    logic [BCD_W-1:0]   acc_adj_s;

    // Next-state and next-output computation for the conversion FSM.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef BIN_TO_BCD_XS3_EN
        xs3_d       = xs3_q;
`endif
        acc_adj_s   = add3_digits(acc_q);

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = ST_SHIFT;
                    bin_d      = bin;
                    acc_d      = {BCD_W{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // {acc, bin} shifted left by one; the accumulator's top bit
                // is always zero after adjustment when DIGITS is legal.
                acc_d = BCD_W'({acc_adj_s, bin_q[BIN_W-1]});
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
`ifdef BIN_TO_BCD_XS3_EN
                    xs3_d       = plus3_digits(acc_d);
`endif
                end else begin
                    state_d     = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= {BIN_W{1'b0}};
            acc_q       <= {BCD_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BIN_TO_BCD_XS3_EN
            xs3_q       <= {BCD_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BIN_TO_BCD_XS3_EN
            xs3_q       <= xs3_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd       = acc_q;
`ifdef BIN_TO_BCD_XS3_EN
    assign xs3       = xs3_q;
`endif

endmodule
